// File: rtl/analog_status_pkg.sv
// ---------------------------------------------------------------------------
// analog_status_pkg
// Shared definitions for the analog status array:
//   - register byte offsets of the APB register map
//   - APB slave FSM state encoding
//   - CTRL register bit positions
//   - byte-strobe to bit-mask helper
// ---------------------------------------------------------------------------
package analog_status_pkg;

    // Register map (byte addresses, word aligned)
    localparam int unsigned STATUS_BASE  = 32'h000;  // STATUS_i at STATUS_BASE + 4*i
    localparam int unsigned CHANGE_BASE  = 32'h100;  // CHANGE_i at CHANGE_BASE + 4*i
    localparam int unsigned IRQ_MASK_OFS = 32'h200;
    localparam int unsigned IRQ_STAT_OFS = 32'h204;
    localparam int unsigned CTRL_OFS     = 32'h208;

    // CTRL register bits
    localparam int unsigned CTRL_FREEZE_BIT = 0;

    // APB slave FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } apb_state_e;

    // Expands the 4 APB byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/status_sync_chan.sv
// ---------------------------------------------------------------------------
// status_sync_chan
// One analog status channel: multi-flop synchroniser, delayed copy for edge
// detection, freezable shadow and sticky per-bit change flags with W1C clear.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   status_i    raw status word from the analog domain
//   freeze_i    1 = shadow holds its value
//   clr_mask_i  one-cycle W1C clear mask for the change flags
//   shadow_o    shadow copy of the synchronised word
//   change_o    sticky change flags
// ---------------------------------------------------------------------------
module status_sync_chan #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] status_i,
    input  logic              freeze_i,
    input  logic [DATA_W-1:0] clr_mask_i,
    output logic [DATA_W-1:0] shadow_o,
    output logic [DATA_W-1:0] change_o
);

    logic [DATA_W-1:0]      sync_q [SYNC_STAGES];
    // Tracks how far real data has travelled down the synchroniser after reset.
    logic [SYNC_STAGES-1:0] fill_q;
    logic [DATA_W-1:0]      prev_q;
    logic [DATA_W-1:0]      shadow_q;
    logic [DATA_W-1:0]      change_q;

    logic [DATA_W-1:0]      sync_last;
    logic [DATA_W-1:0]      sync_d;
    logic                   sync_valid;
    logic [DATA_W-1:0]      change_set;

    assign sync_last  = sync_q[SYNC_STAGES-1];
    assign sync_d     = sync_q[SYNC_STAGES-2];
    assign sync_valid = fill_q[SYNC_STAGES-1];

    // Until the synchroniser holds real data, prev_q is loaded with the same
    // value as sync_q so the first post-reset value never looks like an edge.
    assign change_set = sync_valid ? (sync_last ^ prev_q) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            fill_q   <= '0;
            prev_q   <= '0;
            shadow_q <= '0;
            change_q <= '0;
        end else begin
            sync_q[0] <= status_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_valid ? sync_last : sync_d;
            if (!freeze_i) begin
                shadow_q <= sync_last;
            end
            // Set is applied after clear so a simultaneous set wins.
            change_q <= (change_q & ~clr_mask_i) | change_set;
        end
    end

    assign shadow_o = shadow_q;
    assign change_o = change_q;

endmodule

// File: rtl/analog_status_array_v2.sv
// ---------------------------------------------------------------------------
// analog_status_array_v2
// APB status block for the analog subsystem. NUM_CH status words are
// synchronised, shadowed (freezable for coherent reads) and monitored for
// bit changes; sticky change flags feed a maskable level interrupt.
//
// Ports:
//   clk_in     clock
//   reset      asynchronous active-high reset
//   PADDR, PENABLE, PSEL, PSTRB, PWDATA, PWRITE   APB request
//   PRDATA, PREADY, PSLVERR                        APB response (registered)
//   status_in  packed status, channel i at [i*DATA_W +: DATA_W]
//   irq        registered level interrupt = |(IRQ_MASK & per-channel change)
//
// APB handshake: setup phase (PSEL=1, PENABLE=0) moves IDLE->ACCESS; the
// first PSEL=1/PENABLE=1 cycle in ACCESS decodes, performs the write or
// captures read data and registers PREADY=1 (with PSLVERR) for exactly one
// cycle in RESP. PSEL low in any state returns to IDLE.
// ---------------------------------------------------------------------------
module analog_status_array_v2
    import analog_status_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        PADDR,
    input  logic                     PENABLE,
    input  logic                     PSEL,
    input  logic [3:0]               PSTRB,
    input  logic [31:0]              PWDATA,
    input  logic                     PWRITE,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [NUM_CH*DATA_W-1:0] status_in,
    output logic                     irq
);

    localparam int          PAGE_W   = ADDR_W - 8;
    localparam logic [6:0]  NUM_CH_L = 7'(NUM_CH);

    // Register state
    apb_state_e        state_q;
    logic [31:0]       prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic              irq_q;
    logic [NUM_CH-1:0] irq_mask_q;
    logic              freeze_q;

    // Channel interface
    logic [DATA_W-1:0] shadow_w [NUM_CH];
    logic [DATA_W-1:0] change_w [NUM_CH];
    logic [DATA_W-1:0] clr_w    [NUM_CH];
    logic [NUM_CH-1:0] irq_stat;

    // Address decode
    logic [PAGE_W-1:0] page;
    logic [5:0]        idx;
    logic              idx_ok;
    logic              aligned;
    logic              sel_status;
    logic              sel_change;
    logic              sel_mask;
    logic              sel_stat;
    logic              sel_ctrl;
    logic              addr_err;
    logic              access_fire;
    logic              wr_fire;
    logic [31:0]       wmask;
    logic [31:0]       wdata_masked;
    logic [31:0]       rd_data;

    assign page       = PADDR[ADDR_W-1:8];
    assign idx        = PADDR[7:2];
    assign idx_ok     = ({1'b0, idx} < NUM_CH_L);
    assign aligned    = (PADDR[1:0] == 2'b00);
    assign sel_status = (page == PAGE_W'(STATUS_BASE >> 8)) && idx_ok;
    assign sel_change = (page == PAGE_W'(CHANGE_BASE >> 8)) && idx_ok;
    assign sel_mask   = (PADDR == ADDR_W'(IRQ_MASK_OFS));
    assign sel_stat   = (PADDR == ADDR_W'(IRQ_STAT_OFS));
    assign sel_ctrl   = (PADDR == ADDR_W'(CTRL_OFS));

    // Unmapped, misaligned, out-of-range channel or write to a RO register.
    assign addr_err = !aligned
                    || !(sel_status || sel_change || sel_mask || sel_stat || sel_ctrl)
                    || (PWRITE && (sel_status || sel_stat));

    assign access_fire  = (state_q == ACCESS) && PSEL && PENABLE;
    assign wr_fire      = access_fire && PWRITE && !addr_err;
    assign wmask        = strb_to_mask(PSTRB);
    assign wdata_masked = PWDATA & wmask;

    // Channels
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign clr_w[i] = (wr_fire && sel_change && (idx == 6'(i)))
                          ? wdata_masked[DATA_W-1:0] : '0;

        status_sync_chan #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk_i      (clk_in),
            .rst_i      (reset),
            .status_i   (status_in[i*DATA_W +: DATA_W]),
            .freeze_i   (freeze_q),
            .clr_mask_i (clr_w[i]),
            .shadow_o   (shadow_w[i]),
            .change_o   (change_w[i])
        );

        assign irq_stat[i] = irq_mask_q[i] & (|change_w[i]);
    end

    // Read mux; channel words are zero-extended to 32 bits.
    always_comb begin
        rd_data = '0;
        if (sel_status) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (idx == 6'(i)) begin
                    rd_data[DATA_W-1:0] = shadow_w[i];
                end
            end
        end else if (sel_change) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (idx == 6'(i)) begin
                    rd_data[DATA_W-1:0] = change_w[i];
                end
            end
        end else if (sel_mask) begin
            rd_data[NUM_CH-1:0] = irq_mask_q;
        end else if (sel_stat) begin
            rd_data[NUM_CH-1:0] = irq_stat;
        end else if (sel_ctrl) begin
            rd_data[CTRL_FREEZE_BIT] = freeze_q;
        end
    end

    // APB FSM with registered outputs and RW registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            irq_q      <= 1'b0;
            irq_mask_q <= '0;
            freeze_q   <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= |irq_stat;
            case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= addr_err;
                        prdata_q  <= (addr_err || PWRITE) ? '0 : rd_data;
                        if (wr_fire && sel_mask) begin
                            irq_mask_q <= (irq_mask_q & ~wmask[NUM_CH-1:0])
                                        | wdata_masked[NUM_CH-1:0];
                        end
                        if (wr_fire && sel_ctrl && PSTRB[0]) begin
                            freeze_q <= PWDATA[CTRL_FREEZE_BIT];
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_analog_status_array_v2.sv
// ---------------------------------------------------------------------------
// tb_analog_status_array_v2
// Randomised + directed bench with a register-level reference model. Each
// APB access pushes its expected {PSLVERR, PRDATA} into exp_q; a monitor
// pops and compares whenever PREADY is high.
// ---------------------------------------------------------------------------
module tb_analog_status_array_v2;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 32;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = 16;

    // Clock / reset / DUT signals
    logic                     clk;
    logic                     reset;
    logic [ADDR_W-1:0]        paddr;
    logic                     penable;
    logic                     psel;
    logic [3:0]               pstrb;
    logic [31:0]              pwdata;
    logic                     pwrite;
    logic [31:0]              prdata;
    logic                     pready;
    logic                     pslverr;
    logic [NUM_CH*DATA_W-1:0] status_in;
    logic                     irq;

    analog_status_array_v2 #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_in    (clk),
        .reset     (reset),
        .PADDR     (paddr),
        .PENABLE   (penable),
        .PSEL      (psel),
        .PSTRB     (pstrb),
        .PWDATA    (pwdata),
        .PWRITE    (pwrite),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .status_in (status_in),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents as seen by software
    logic [31:0] m_in     [NUM_CH];
    logic [31:0] m_shadow [NUM_CH];
    logic [31:0] m_change [NUM_CH];
    logic [31:0] m_mask;
    logic        m_freeze;

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    logic        pready_prev;

    function automatic logic [31:0] model_irq_stat();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s[i] = m_mask[i] && (m_change[i] != 0);
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_change[i] = '0;
            m_shadow[i] = m_in[i];
        end
        m_mask   = '0;
        m_freeze = 1'b0;
    endtask

    // Applies one APB access to the model and returns the expected response.
    task automatic model_access(input logic wr, input logic [15:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                output logic [32:0] resp);
        logic [31:0] bm;
        logic [31:0] rd;
        logic        err;
        int          ch;
        bm = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        err = 1'b1;
        rd  = '0;
        if (addr[1:0] == 2'b00) begin
            if (addr < 16'h100) begin
                ch = int'(addr) / 4;
                if (ch < NUM_CH && !wr) begin
                    err = 1'b0;
                    rd  = m_shadow[ch];
                end
            end else if (addr < 16'h200) begin
                ch = (int'(addr) - 'h100) / 4;
                if (ch < NUM_CH) begin
                    err = 1'b0;
                    if (wr) m_change[ch] = m_change[ch] & ~(data & bm);
                    else    rd = m_change[ch];
                end
            end else if (addr == 16'h200) begin
                err = 1'b0;
                if (wr) m_mask = ((m_mask & ~bm) | (data & bm)) & ((32'd1 << NUM_CH) - 1);
                else    rd = m_mask;
            end else if (addr == 16'h204) begin
                if (!wr) begin
                    err = 1'b0;
                    rd  = model_irq_stat();
                end
            end else if (addr == 16'h208) begin
                err = 1'b0;
                if (wr) begin
                    if (strb[0]) m_freeze = data[0];
                    if (!m_freeze) begin
                        for (int i = 0; i < NUM_CH; i++) m_shadow[i] = m_in[i];
                    end
                end else begin
                    rd = {31'b0, m_freeze};
                end
            end
        end
        resp = {err, (wr || err) ? 32'h0 : rd};
    endtask

    // Driver tasks
    task automatic apb_xfer(input logic wr, input logic [15:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic [32:0] resp;
        logic        got;
        model_access(wr, addr, data, strb, resp);
        exp_q.push_back(resp);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL apb_timeout addr=%h got no PREADY, required PREADY within 8 cycles", addr);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr);
        apb_xfer(1'b0, addr, 32'h0, 4'h0);
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        apb_xfer(1'b1, addr, data, strb);
    endtask

    task automatic drive_status(input int ch, input logic [31:0] val);
        @(posedge clk); #1;
        status_in[ch*DATA_W +: DATA_W] = val;
        m_change[ch] = m_change[ch] | (m_in[ch] ^ val);
        m_in[ch] = val;
        if (!m_freeze) m_shadow[ch] = val;
        repeat (SYNC_STAGES + 3) @(posedge clk);
    endtask

    task automatic check_irq(input string name);
        logic exp;
        @(negedge clk);
        exp = |model_irq_stat();
        n_checks++;
        if (irq !== exp) begin
            n_fail++;
            $display("FAIL %s irq got %b required %b", name, irq, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 6))
            0: a = 16'(4 * $urandom_range(0, NUM_CH));
            1: a = 16'(16'h100 + 4 * $urandom_range(0, NUM_CH));
            2: a = 16'h200;
            3: a = 16'h204;
            4: a = 16'h208;
            5: a = ($urandom_range(0, 1) != 0) ? 16'h20C : 16'h300;
            default: begin
                a = 16'($urandom_range(0, 'h2FF));
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end
        endcase
        return a;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (pready_prev) begin
            n_checks++;
            if (pready) begin
                n_fail++;
                $display("FAIL pready_width PREADY high 2 cycles, required 1");
            end
        end
        if (pready && !pready_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pready got PREADY with no pending access");
            end else begin
                e = exp_q.pop_front();
                if ({pslverr, prdata} !== e) begin
                    n_fail++;
                    $display("FAIL apb_resp got err=%b data=%h required err=%b data=%h",
                             pslverr, prdata, e[32], e[31:0]);
                end
            end
        end
        pready_prev = pready;
    end

    // Main sequence
    initial begin
        int op;
        int ch;
        n_checks = 0;
        n_fail = 0;
        pready_prev = 1'b0;
        reset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        status_in = '0;
        for (int i = 0; i < NUM_CH; i++) m_in[i] = '0;
        model_reset();

        // Reset values
        @(negedge clk);
        check_val("reset_prdata", prdata, 32'h0);
        check_val("reset_pready", {31'b0, pready}, 32'h0);
        check_val("reset_pslverr", {31'b0, pslverr}, 32'h0);
        check_val("reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (SYNC_STAGES + 3) @(posedge clk);

        // Idle reads
        for (int i = 0; i < NUM_CH; i++) apb_read(16'(4 * i));
        apb_read(16'h100);

        // Channel 2 change, mask, byte-strobed clear
        drive_status(2, 32'hA5A5_0001);
        apb_read(16'h008);
        apb_read(16'h108);
        apb_write(16'h200, 32'h4, 4'hF);
        check_irq("irq_after_mask");
        apb_write(16'h108, 32'h0000_0001, 4'h1);
        apb_read(16'h108);
        check_irq("irq_partial_clear");
        apb_write(16'h108, 32'hFFFF_FFFF, 4'hF);
        check_irq("irq_full_clear");

        // Freeze
        drive_status(0, 32'h10);
        apb_write(16'h100, 32'hFFFF_FFFF, 4'hF);
        apb_write(16'h208, 32'h1, 4'hF);
        drive_status(0, 32'h20);
        apb_read(16'h000);
        apb_read(16'h100);
        apb_read(16'h208);
        apb_write(16'h208, 32'h0, 4'hF);
        apb_read(16'h000);

        // Set and clear of the same change bit in the same cycle
        apb_write(16'h104, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        status_in[1*DATA_W] = ~status_in[1*DATA_W];
        m_in[1] = m_in[1] ^ 32'h1;
        if (!m_freeze) m_shadow[1] = m_in[1];
        repeat (SYNC_STAGES - 2) @(posedge clk);
        apb_write(16'h104, 32'h1, 4'h1);
        m_change[1] = m_change[1] | 32'h1;
        apb_read(16'h104);

        // Error cases, then confirm nothing moved
        apb_read(16'h010);
        apb_read(16'h202);
        apb_write(16'h000, 32'hDEAD_BEEF, 4'hF);
        apb_read(16'h300);
        apb_write(16'h204, 32'hF, 4'hF);
        apb_read(16'h000);
        apb_read(16'h200);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    ch = $urandom_range(0, NUM_CH - 1);
                    if ($urandom_range(0, 1) != 0) drive_status(ch, $urandom);
                    else drive_status(ch, m_in[ch] ^ (32'h1 << $urandom_range(0, 31)));
                end
                1, 2: apb_read(rand_addr());
                3: apb_write(16'(16'h100 + 4 * $urandom_range(0, NUM_CH - 1)),
                             $urandom, 4'($urandom_range(0, 15)));
                4: apb_write(16'h200, $urandom, 4'($urandom_range(0, 15)));
                default: apb_write(($urandom_range(0, 3) != 0) ? 16'h208 : rand_addr(),
                                   $urandom, 4'($urandom_range(0, 15)));
            endcase
            check_irq("irq_random");
        end

        // Reset during ACCESS of a read
        apb_write(16'h200, 32'hF, 4'hF);
        drive_status(3, m_in[3] ^ 32'h0000_0100);
        check_irq("irq_before_reset");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h000;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("midreset_pready", {31'b0, pready}, 32'h0);
        check_val("midreset_irq", {31'b0, irq}, 32'h0);
        check_val("midreset_pslverr", {31'b0, pslverr}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        psel = 1'b0; penable = 1'b0;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        apb_read(16'h200);
        apb_read(16'h000);
        apb_read(16'h10C);
        check_irq("irq_after_reset");

        repeat (4) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending responses, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
